cpu_axi_bridge: RTL and testbench

//  Converts the CPU's two SRAM-like ports (instruction fetch, data access) into one

---
 rtl/cpu_axi_bridge_pkg.sv | 24 ++
 rtl/cpu_axi_bridge.sv | 175 +++++++++++++++++
 tb/tb_cpu_axi_bridge.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_axi_bridge_pkg.sv
// Shared definitions for the CPU-to-AXI bridge: FSM states, AXI IDs and size codes.
package cpu_axi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_ADDR = 3'd3,
    ST_WR_RESP = 3'd4
  } state_t;

  localparam logic [3:0] INST_ID = 4'd0;
  localparam logic [3:0] DATA_ID = 4'd1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // AXI size code from the CPU's two-bit size field
  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/cpu_axi_bridge.sv
// Bridges the CPU's inst/data SRAM-like ports onto one single-beat AXI master,
// one transaction in flight, data port preferred over inst port.
module cpu_axi_bridge
  import cpu_axi_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  inst_req,
  input  logic [ADDR_W-1:0]     inst_addr,
  output logic                  inst_addr_ok,
  output logic                  inst_data_ok,
  output logic [DATA_W-1:0]     inst_rdata,
  input  logic                  data_req,
  input  logic                  data_wr,
  input  logic [1:0]            data_size,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W/8-1:0]   data_wstrb,
  input  logic [DATA_W-1:0]     data_wdata,
  output logic                  data_addr_ok,
  output logic                  data_data_ok,
  output logic [DATA_W-1:0]     data_rdata,
  output logic [3:0]            arid,
  output logic [ADDR_W-1:0]     araddr,
  output logic [2:0]            arsize,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [3:0]            rid,
  input  logic [DATA_W-1:0]     rdata,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [3:0]            awid,
  output logic [ADDR_W-1:0]     awaddr,
  output logic [2:0]            awsize,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic                  bvalid,
  output logic                  bready
);

  state_t                state_r;
  logic                  owner_r;  // 1 = data port owns the transaction
  logic                  arvalid_r, rready_r, awvalid_r, wvalid_r, bready_r;
  logic [3:0]            arid_r;
  logic [ADDR_W-1:0]     araddr_r, awaddr_r;
  logic [2:0]            arsize_r, awsize_r;
  logic [DATA_W-1:0]     wdata_r;
  logic [DATA_W/8-1:0]   wstrb_r;
  logic                  idle_s, rd_hs_s, wr_hs_s, aw_done_s, w_done_s;

  assign idle_s    = (state_r == ST_IDLE);
  assign rd_hs_s   = rvalid & rready_r;
  assign wr_hs_s   = bvalid & bready_r;
  assign aw_done_s = ~awvalid_r | awready;
  assign w_done_s  = ~wvalid_r | wready;

  assign data_addr_ok = idle_s & data_req;
  assign inst_addr_ok = idle_s & inst_req & ~data_req;
  assign inst_data_ok = rd_hs_s & ~owner_r & (rid == INST_ID);
  assign data_data_ok = (rd_hs_s & owner_r & (rid == DATA_ID)) | wr_hs_s;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  assign arid    = arid_r;
  assign araddr  = araddr_r;
  assign arsize  = arsize_r;
  assign arvalid = arvalid_r;
  assign rready  = rready_r;
  assign awid    = DATA_ID;
  assign awaddr  = awaddr_r;
  assign awsize  = awsize_r;
  assign awvalid = awvalid_r;
  assign wdata   = wdata_r;
  assign wstrb   = wstrb_r;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_r;
  assign bready  = bready_r;

  // Transaction FSM with all AXI-side controls held in registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= ST_IDLE;
      owner_r   <= 1'b0;
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
      awvalid_r <= 1'b0;
      wvalid_r  <= 1'b0;
      bready_r  <= 1'b0;
      arid_r    <= 4'd0;
      araddr_r  <= '0;
      arsize_r  <= 3'd0;
      awaddr_r  <= '0;
      awsize_r  <= 3'd0;
      wdata_r   <= '0;
      wstrb_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (data_req) begin
            owner_r <= 1'b1;
            if (data_wr) begin
              awaddr_r  <= data_addr;
              awsize_r  <= axi_size(data_size);
              wdata_r   <= data_wdata;
              wstrb_r   <= data_wstrb;
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
              state_r   <= ST_WR_ADDR;
            end else begin
              arid_r    <= DATA_ID;
              araddr_r  <= data_addr;
              arsize_r  <= axi_size(data_size);
              arvalid_r <= 1'b1;
              state_r   <= ST_RD_ADDR;
            end
          end else if (inst_req) begin
            owner_r   <= 1'b0;
            arid_r    <= INST_ID;
            araddr_r  <= inst_addr;
            arsize_r  <= axi_size(SIZE_WORD);
            arvalid_r <= 1'b1;
            state_r   <= ST_RD_ADDR;
          end
        end
        ST_RD_ADDR: begin
          if (arready) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            state_r   <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (rvalid) begin
            rready_r <= 1'b0;
            state_r  <= ST_IDLE;
          end
        end
        ST_WR_ADDR: begin
          // AW and W complete independently; a dropped valid marks that channel done
          if (aw_done_s && w_done_s) begin
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b1;
            state_r   <= ST_WR_RESP;
          end else begin
            if (awready) awvalid_r <= 1'b0;
            if (wready)  wvalid_r  <= 1'b0;
          end
        end
        ST_WR_RESP: begin
          if (bvalid) begin
            bready_r <= 1'b0;
            state_r  <= ST_IDLE;
          end
        end
        default: begin
          arvalid_r <= 1'b0;
          rready_r  <= 1'b0;
          awvalid_r <= 1'b0;
          wvalid_r  <= 1'b0;
          bready_r  <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed plus randomized bench: the bench plays both CPU and AXI slave,
// with a word-addressed memory model supplying read data and absorbing stores.
module tb_cpu_axi_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid, rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic        bvalid, bready;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] mem [logic [31:0]];

  cpu_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    inst_req = 1'b0; inst_addr = 32'd0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'd0;
    data_wstrb = 4'd0; data_wdata = 32'd0;
    arready = 1'b0; rvalid = 1'b0; rid = 4'd0; rdata = 32'd0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
  endtask

  // CPU keeps asking while the bridge is busy; nothing may be accepted
  task automatic poke(input bit hold_inst);
    inst_req  = hold_inst ? 1'b1 : 1'($urandom_range(0, 1));
    inst_addr = $urandom;
    data_req  = 1'($urandom_range(0, 1));
    data_wr   = 1'($urandom_range(0, 1));
    data_addr = $urandom;
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] key;
    key = {a[31:2], 2'b00};
    if (mem.exists(key)) return mem[key];
    else return key ^ 32'hA5A5_5A5A;
  endfunction

  task automatic do_read(input bit is_data, input bit both, input logic [31:0] addr,
                         input logic [1:0] size, input int ar_wait, input int r_wait);
    logic [3:0]  id;
    logic [2:0]  sz;
    logic [31:0] exp;
    id  = is_data ? 4'd1 : 4'd0;
    sz  = is_data ? {1'b0, size} : 3'd2;
    exp = mem_rd(addr);
    if (is_data) begin
      data_req = 1'b1; data_wr = 1'b0; data_size = size; data_addr = addr;
      inst_req = both; inst_addr = 32'hBFC0_0100;
    end else begin
      inst_req = 1'b1; inst_addr = addr; data_req = 1'b0;
    end
    mid();
    check("rd_winner_addr_ok", is_data ? data_addr_ok : inst_addr_ok, 32'd1);
    check("rd_loser_addr_ok", is_data ? inst_addr_ok : data_addr_ok, 32'd0);
    check("rd_t0_arvalid", arvalid, 32'd0);
    for (int k = 0; k <= ar_wait; k++) begin
      step(); poke(both);
      arready = (k == ar_wait);
      mid();
      check("rd_arvalid", arvalid, 32'd1);
      check("rd_araddr", araddr, addr);
      check("rd_arsize", arsize, sz);
      check("rd_arid", arid, id);
      check("rd_rready_early", rready, 32'd0);
      check("rd_busy_addr_ok", {inst_addr_ok, data_addr_ok}, 32'd0);
      check("rd_early_data_ok", {inst_data_ok, data_data_ok}, 32'd0);
    end
    for (int k = 0; k <= r_wait; k++) begin
      step(); poke(both);
      arready = 1'b0;
      rvalid = (k == r_wait); rid = id; rdata = exp;
      mid();
      check("rd_rready", rready, 32'd1);
      check("rd_arvalid_low", arvalid, 32'd0);
      check("rd_busy_addr_ok", {inst_addr_ok, data_addr_ok}, 32'd0);
      check("rd_inst_data_ok", inst_data_ok, 32'((k == r_wait) && !is_data));
      check("rd_data_data_ok", data_data_ok, 32'((k == r_wait) && is_data));
      if (k == r_wait) check("rd_rdata", is_data ? data_rdata : inst_rdata, exp);
    end
    step(); idle_inputs();
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [1:0] size, input logic [3:0] strb,
                          input logic [31:0] wd, input int aw_wait, input int w_wait, input int b_wait);
    int n, aw_beats, w_beats, ok_cnt;
    logic [31:0] key, word;
    data_req = 1'b1; data_wr = 1'b1; data_size = size; data_addr = addr;
    data_wstrb = strb; data_wdata = wd; inst_req = 1'($urandom_range(0, 1));
    mid();
    check("wr_addr_ok", data_addr_ok, 32'd1);
    check("wr_inst_loses", inst_addr_ok, 32'd0);
    check("wr_t0_valids", {awvalid, wvalid}, 32'd0);
    n = (aw_wait > w_wait) ? aw_wait : w_wait;
    aw_beats = 0; w_beats = 0; ok_cnt = 0;
    for (int c = 0; c <= n; c++) begin
      step(); poke(1'b0);
      data_wdata = $urandom; data_wstrb = 4'($urandom);
      awready = (c == aw_wait); wready = (c == w_wait);
      mid();
      check("wr_awvalid", awvalid, 32'(c <= aw_wait));
      check("wr_wvalid", wvalid, 32'(c <= w_wait));
      check("wr_awaddr", awaddr, addr);
      check("wr_awsize", awsize, {29'd0, 1'b0, size});
      check("wr_wstrb", wstrb, strb);
      check("wr_wdata", wdata, wd);
      check("wr_ids", {awid, 3'd0, wlast}, 32'h11);
      check("wr_bready_early", bready, 32'd0);
      check("wr_busy_addr_ok", {inst_addr_ok, data_addr_ok}, 32'd0);
      if (awvalid && awready) aw_beats++;
      if (wvalid && wready) w_beats++;
    end
    check("wr_aw_beats", aw_beats, 32'd1);
    check("wr_w_beats", w_beats, 32'd1);
    for (int k = 0; k <= b_wait; k++) begin
      step(); poke(1'b0);
      awready = 1'b0; wready = 1'b0; bvalid = (k == b_wait);
      mid();
      check("wr_bready", bready, 32'd1);
      check("wr_valids_low", {awvalid, wvalid}, 32'd0);
      check("wr_inst_data_ok", inst_data_ok, 32'd0);
      check("wr_data_data_ok", data_data_ok, 32'(k == b_wait));
      check("wr_busy_addr_ok", {inst_addr_ok, data_addr_ok}, 32'd0);
      if (data_data_ok) ok_cnt++;
    end
    check("wr_ok_once", ok_cnt, 32'd1);
    step(); idle_inputs();
    key = {addr[31:2], 2'b00};
    word = mem_rd(addr);
    for (int b = 0; b < 4; b++) if (strb[b]) word[8*b +: 8] = wd[8*b +: 8];
    mem[key] = word;
  endtask

  function automatic logic [3:0] strb_for(input logic [1:0] size, input logic [31:0] a);
    case (size)
      2'd0:    return 4'b0001 << a[1:0];
      2'd1:    return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  initial begin
    int kind;
    logic [1:0]  sz;
    logic [31:0] a;
    idle_inputs();
    resetn = 1'b0;
    repeat (2) mid();
    check("rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 32'd0);
    check("rst_ok", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 32'd0);
    check("rst_araddr", araddr, 32'd0);
    check("rst_awaddr", awaddr, 32'd0);
    resetn = 1'b1;
    step();

    // Basic fetch, zero-wait slave
    do_read(1'b0, 1'b0, 32'hBFC0_0000, 2'd2, 0, 0);
    // Data beats inst in the same cycle; inst follows right after data_ok
    do_read(1'b1, 1'b1, 32'h0000_1000, 2'd2, 0, 0);
    do_read(1'b0, 1'b0, 32'hBFC0_0100, 2'd2, 0, 0);
    // Store word, W accepted three cycles before AW
    do_write(32'h0000_2000, 2'd2, 4'hF, 32'hDEAD_BEEF, 3, 0, 0);
    do_read(1'b1, 1'b0, 32'h0000_2000, 2'd2, 0, 0);
    // Byte store into lane 2
    do_write(32'h0000_3002, 2'd0, 4'h4, 32'h00AB_0000, 0, 0, 1);
    do_read(1'b1, 1'b0, 32'h0000_3000, 2'd2, 1, 0);
    // Slow read data while the CPU keeps requesting
    do_read(1'b1, 1'b1, 32'h0000_4004, 2'd2, 0, 10);
    // AW before W, and a slow response
    do_write(32'h0000_5000, 2'd1, 4'h3, 32'h0000_1234, 0, 2, 3);

    // Reset while the write address/data are pending
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h0000_6000;
    data_wstrb = 4'hF; data_wdata = 32'h1111_2222;
    mid();
    check("rst_wr_accept", data_addr_ok, 32'd1);
    step(); idle_inputs();
    mid();
    check("rst_wr_pending", {awvalid, wvalid}, 32'h3);
    #2 resetn = 1'b0;
    #1;
    check("rst_async_valids", {arvalid, awvalid, wvalid, rready, bready}, 32'd0);
    step(); step();
    mid();
    check("rst_held_valids", {arvalid, awvalid, wvalid, rready, bready}, 32'd0);
    resetn = 1'b1;
    step();
    do_read(1'b0, 1'b0, 32'hBFC0_0200, 2'd2, 0, 0);

    // Randomized traffic over a small address window so reads revisit stores
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      sz   = 2'($urandom_range(0, 2));
      a    = 32'h0000_8000 + 32'($urandom_range(0, 7)) * 32'd4 + 32'($urandom_range(0, 3));
      if (sz == 2'd1) a[0] = 1'b0;
      if (sz == 2'd2 || kind == 0) a[1:0] = 2'b00;
      case (kind)
        0:       do_read(1'b0, 1'b0, a, 2'd2, $urandom_range(0, 3), $urandom_range(0, 3));
        1:       do_read(1'b1, 1'($urandom_range(0, 1)), a, sz, $urandom_range(0, 3), $urandom_range(0, 3));
        default: do_write(a, sz, strb_for(sz, a), $urandom, $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 3));
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
